// File: rtl/cnt8_down_timer_if.sv
// Control/status bundle for the programmable down-counting timer.
// The master loads and steers the timer; the slave (the timer) reports count, tc and busy.
interface cnt8_down_timer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             enable;
  logic             auto_reload;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;

  modport master (
    output load, load_val, enable, auto_reload, stop,
    input  count, tc, busy
  );

  modport slave (
    input  load, load_val, enable, auto_reload, stop,
    output count, tc, busy
  );
endinterface

// File: rtl/cnt8_down_timer.sv
// Programmable down-counting timer with one-shot and auto-reload modes.
// Emits a registered one-cycle tc pulse after each terminal decrement (count 1 -> reload/0).
module cnt8_down_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  cnt8_down_timer_if.slave      bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] reload_reg;
  logic             tc_r;
  logic             busy_r;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      count_r    <= '0;
      reload_reg <= '0;
      tc_r       <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      tc_r <= 1'b0;
      if (bus.load) begin
        // A load in RUN discards any pending decrement, so no tc even at count==1.
        count_r    <= bus.load_val;
        reload_reg <= bus.load_val;
        if (bus.load_val != '0) begin
          state  <= RUN;
          busy_r <= 1'b1;
        end else begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      end else if (state == RUN) begin
        if (bus.stop) begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end else if (bus.enable) begin
          if (count_r == WIDTH'(1)) begin
            tc_r <= 1'b1;
            if (bus.auto_reload) begin
              count_r <= reload_reg;
            end else begin
              count_r <= '0;
              state   <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            count_r <= count_r - WIDTH'(1);
          end
        end
      end
    end
  end

  assign bus.count = count_r;
  assign bus.tc    = tc_r;
  assign bus.busy  = busy_r;

endmodule
